cmac_bp_drain_ctl: RTL and testbench

//  Autonomous drain sequencer for the CMAC back-pressure event FIFO. Replaces software polling.

---
 rtl/cmac_bp_drain_ctl.sv | 195 +++++++++++++++++++
 tb/tb_cmac_bp_drain_ctl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmac_bp_drain_ctl.sv
// ---------------------------------------------------------------------------------------------
// cmac_bp_drain_ctl
//
// Autonomous drain sequencer for the CMAC back-pressure event FIFO. While enabled it pops each
// head entry (length / rxad / timestamp), packs it with a 16-bit sequence number into a 128-bit
// AXI-Stream record, and keeps saturating event, stall and drop statistics.
//
// Record layout (m_axis_tdata):
//   [127:112] seq   [111:97] zero   [96] rxad   [95:64] length   [63:0] timestamp
//
// Parameters
//   POP_LAT       cycles after a bp_next pulse before bp_* are valid again (>= 1)
//   DROP_TIMEOUT  stall cycles before a held record is discarded (drop build only)
//
// Build option
//   CMAC_BP_DROP_EN  when defined, a per-record stall timer discards a record that has waited
//                    DROP_TIMEOUT stalled cycles. When undefined, SEND waits indefinitely, the
//                    timer is not built and drop_count is tied to zero.
//
// Ports
//   clk, resetn             clock, asynchronous active-low reset
//   enable                  1 = drain automatically; 0 = stop after the current record
//   clear_stats             1-cycle pulse, zeroes all statistics (wins over an increment)
//   bp_valid, bp_length,    FIFO head entry
//   bp_rxad, bp_timestamp
//   bp_next                 1-cycle pop strobe to the FIFO (combinational, same cycle as capture)
//   m_axis_tdata/tvalid     record stream, registered
//   m_axis_tready           downstream ready
//   busy                    record held or pop settling in progress
//   event_count             records emitted (saturating)
//   stall_count             cycles with tvalid=1 and tready=0 (saturating)
//   drop_count              records discarded on timeout (saturating)
// ---------------------------------------------------------------------------------------------
module cmac_bp_drain_ctl #(
  parameter int unsigned POP_LAT      = 2,
  parameter int unsigned DROP_TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          enable,
  input  logic          clear_stats,
  input  logic          bp_valid,
  input  logic [31:0]   bp_length,
  input  logic          bp_rxad,
  input  logic [63:0]   bp_timestamp,
  output logic          bp_next,
  output logic [127:0]  m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          busy,
  output logic [31:0]   event_count,
  output logic [31:0]   stall_count,
  output logic [31:0]   drop_count
);

  // Elaboration-time sanity check on the configuration.
  if (POP_LAT < 1 || DROP_TIMEOUT < 1) begin : g_param_check
    $error("cmac_bp_drain_ctl: POP_LAT and DROP_TIMEOUT must both be >= 1");
  end

  localparam int unsigned SettleW = (POP_LAT < 2) ? 1 : $clog2(POP_LAT + 1);
  localparam logic [SettleW-1:0] SettleLoad = SettleW'(POP_LAT);

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } state_e;

  state_e               r_state;
  logic [SettleW-1:0]   r_settle;
  logic [15:0]          r_seq;
  logic                 r_tvalid;
  logic [127:0]         r_tdata;
  logic [31:0]          r_event_cnt;
  logic [31:0]          r_stall_cnt;

  logic                 w_pop;
  logic                 w_hshk;
  logic                 w_stall;
  logic                 w_timeout;

  // A capture and its pop happen in the same cycle; the settle counter then blocks the next
  // capture until the FIFO head has had POP_LAT cycles to update.
  assign w_pop   = (r_state == StIdle) && enable && bp_valid && (r_settle == '0);
  assign w_hshk  = (r_state == StSend) && m_axis_tready;
  assign w_stall = (r_state == StSend) && !m_axis_tready;

`ifdef CMAC_BP_DROP_EN
  localparam int unsigned TmrW = (DROP_TIMEOUT < 2) ? 1 : $clog2(DROP_TIMEOUT);

  logic [TmrW-1:0]      r_stall_tmr;
  logic [31:0]          r_drop_cnt;

  // Fires on the DROP_TIMEOUT-th stalled cycle of the current record. A handshake in that
  // cycle is impossible by construction since w_stall requires tready=0, so a late handshake
  // always counts as sent.
  assign w_timeout = w_stall && (r_stall_tmr == TmrW'(DROP_TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_tmr <= '0;
    end else if (w_pop) begin
      r_stall_tmr <= '0;
    end else if (w_stall) begin
      r_stall_tmr <= r_stall_tmr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_drop_cnt <= '0;
    end else if (clear_stats) begin
      r_drop_cnt <= '0;
    end else if (w_timeout && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign drop_count = r_drop_cnt;
`else
  assign w_timeout  = 1'b0;
  assign drop_count = '0;
`endif

  // Main sequencer: state, settle counter, sequence number and the registered record.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= StIdle;
      r_settle <= '0;
      r_seq    <= '0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
    end else begin
      if (w_pop) begin
        r_settle <= SettleLoad;
      end else if (r_settle != '0) begin
        r_settle <= r_settle - 1'b1;
      end

      case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_tdata  <= {r_seq, 15'b0, bp_rxad, bp_length, bp_timestamp};
            r_tvalid <= 1'b1;
            r_state  <= StSend;
          end
        end
        StSend: begin
          if (m_axis_tready) begin
            r_tvalid <= 1'b0;
            r_seq    <= r_seq + 16'd1;
            r_state  <= StIdle;
          end else if (w_timeout) begin
            // Dropped record: seq is not consumed.
            r_tvalid <= 1'b0;
            r_state  <= StIdle;
          end
        end
        default: begin
          r_tvalid <= 1'b0;
          r_state  <= StIdle;
        end
      endcase
    end
  end

  // Statistics; clear_stats takes priority over a coincident increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_event_cnt <= '0;
    end else if (clear_stats) begin
      r_event_cnt <= '0;
    end else if (w_hshk && (r_event_cnt != '1)) begin
      r_event_cnt <= r_event_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (clear_stats) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bp_next       = w_pop;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign busy          = (r_state == StSend) || (r_settle != '0);
  assign event_count   = r_event_cnt;
  assign stall_count   = r_stall_cnt;

endmodule

// File: tb/tb_cmac_bp_drain_ctl.sv
// Directed bench for cmac_bp_drain_ctl with a small behavioural bp-event FIFO.
module tb_cmac_bp_drain_ctl;

  localparam int unsigned POP_LAT = 2;
`ifdef CMAC_BP_DROP_EN
  localparam int unsigned DROP_TO = 16;
  localparam int          STALL_N = 10;
`else
  localparam int unsigned DROP_TO = 1024;
  localparam int          STALL_N = 50;
`endif

  logic         clk;
  logic         resetn;
  logic         enable;
  logic         clear_stats;
  logic         bp_valid;
  logic [31:0]  bp_length;
  logic         bp_rxad;
  logic [63:0]  bp_timestamp;
  logic         bp_next;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         busy;
  logic [31:0]  event_count;
  logic [31:0]  stall_count;
  logic [31:0]  drop_count;

  cmac_bp_drain_ctl #(
    .POP_LAT      (POP_LAT),
    .DROP_TIMEOUT (DROP_TO)
  ) u_dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .clear_stats   (clear_stats),
    .bp_valid      (bp_valid),
    .bp_length     (bp_length),
    .bp_rxad       (bp_rxad),
    .bp_timestamp  (bp_timestamp),
    .bp_next       (bp_next),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .event_count   (event_count),
    .stall_count   (stall_count),
    .drop_count    (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- FIFO model ----------------
  logic [96:0] f_mem [0:31];
  int          f_wr   = 0;
  int          f_rd   = 0;
  int          f_hide = 0;
  logic [4:0]  f_idx;
  logic        pop_pend = 1'b0;

  assign f_idx    = f_rd[4:0];
  assign bp_valid = (f_wr != f_rd) && (f_hide == 0);
  assign {bp_rxad, bp_length, bp_timestamp} = f_mem[f_idx];

  // Pop takes effect just after the edge that closed the bp_next cycle; head hidden meanwhile.
  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      f_rd   = f_rd + 1;
      f_hide = POP_LAT - 1;
    end else if (f_hide > 0) begin
      f_hide = f_hide - 1;
    end
  end

  // ---------------- Monitor (negedge) ----------------
  int           cyc_n    = 0;
  int           pops     = 0;
  int           viol     = 0;
  int           last_pop = -100;
  int           hs_cnt   = 0;
  int           unstable = 0;
  logic [127:0] hs_data [0:63];
  int           hs_cyc  [0:63];
  logic         held     = 1'b0;
  logic [127:0] held_data;

  always @(negedge clk) begin
    cyc_n    = cyc_n + 1;
    pop_pend = bp_next;
    if (!resetn) last_pop = -100;
    if (bp_next) begin
      pops = pops + 1;
      if (!bp_valid) viol = viol + 1;
      if (cyc_n - last_pop < int'(POP_LAT) + 1) viol = viol + 1;
      last_pop = cyc_n;
    end
    if (resetn && m_axis_tvalid && m_axis_tready) begin
      hs_data[hs_cnt[5:0]] = m_axis_tdata;
      hs_cyc[hs_cnt[5:0]]  = cyc_n;
      hs_cnt = hs_cnt + 1;
    end
    if (held && m_axis_tvalid && (m_axis_tdata != held_data)) unstable = unstable + 1;
    held      = m_axis_tvalid && !m_axis_tready;
    held_data = m_axis_tdata;
  end

  // ---------------- Checking helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests = n_tests + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] len, input logic rx, input logic [63:0] ts);
    f_mem[f_wr[4:0]] = {rx, len, ts};
    f_wr = f_wr + 1;
  endtask

  int n_pops0;
  int n_hs0;
  int k;

  initial begin
    resetn        = 1'b0;
    enable        = 1'b0;
    clear_stats   = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", {127'd0, m_axis_tvalid}, 128'd0);
    chk("rst_tdata", m_axis_tdata, 128'd0);
    chk("rst_bp_next", {127'd0, bp_next}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_counts", {32'd0, event_count, stall_count, drop_count}, 128'd0);
    resetn = 1'b1;
    cyc(2);

    // 1: single event, one-cycle latency
    push(32'h40, 1'b1, 64'h1_0000_0002);
    enable        = 1'b1;
    m_axis_tready = 1'b1;
    cyc();
    chk("t1_tvalid", {127'd0, m_axis_tvalid}, 128'd1);
    chk("t1_tdata", m_axis_tdata, 128'h0000_0001_0000_0040_0000_0001_0000_0002);
    chk("t1_busy", {127'd0, busy}, 128'd1);
    cyc(4);
    chk("t1_pops", 128'(pops), 128'd1);
    chk("t1_hs", 128'(hs_cnt), 128'd1);
    chk("t1_event", {96'd0, event_count}, 128'd1);
    chk("t1_idle", {126'd0, busy, m_axis_tvalid}, 128'd0);

    // 2: burst of 8, one record per POP_LAT+1 cycles
    for (int i = 0; i < 8; i++) push(32'h100 + 32'(i), i[0], 64'(i) * 64'h10);
    cyc(30);
    chk("t2_pops", 128'(pops), 128'd9);
    chk("t2_hs", 128'(hs_cnt), 128'd9);
    chk("t2_event", {96'd0, event_count}, 128'd9);
    for (int i = 0; i < 8; i++) begin
      k = 1 + i;
      chk("t2_seq", {112'd0, hs_data[k][127:112]}, 128'(i + 1));
      chk("t2_len", {96'd0, hs_data[k][95:64]}, 128'(32'h100 + 32'(i)));
    end
    for (int i = 1; i < 8; i++) begin
      chk("t2_gap", 128'(hs_cyc[i + 1] - hs_cyc[i]), 128'(POP_LAT + 1));
    end
    chk("t2_viol", 128'(viol), 128'd0);

    // 3: back-pressure, tdata stable, no pop until handshake
    n_pops0 = pops;
    n_hs0   = hs_cnt;
    m_axis_tready = 1'b0;
    push(32'hAA, 1'b0, 64'hDEAD);
    push(32'hBB, 1'b1, 64'hBEEF);
    cyc();
    chk("t3_tvalid", {127'd0, m_axis_tvalid}, 128'd1);
    cyc(STALL_N);
    chk("t3_stall", {96'd0, stall_count}, 128'(STALL_N));
    chk("t3_nopop", 128'(pops), 128'(n_pops0 + 1));
    chk("t3_held", {127'd0, m_axis_tvalid}, 128'd1);
    chk("t3_nohs", 128'(hs_cnt), 128'(n_hs0));
    m_axis_tready = 1'b1;
    cyc(8);
    chk("t3_pops", 128'(pops), 128'(n_pops0 + 2));
    chk("t3_hs", 128'(hs_cnt), 128'(n_hs0 + 2));
    chk("t3_len", {96'd0, hs_data[n_hs0][95:64]}, 128'h0AA);
    chk("t3_stall_end", {96'd0, stall_count}, 128'(STALL_N));
    chk("t3_stable", 128'(unstable), 128'd0);
    chk("t3_event", {96'd0, event_count}, 128'd11);

    // 4: disable while a record is in SEND with 3 entries queued
    n_pops0 = pops;
    n_hs0   = hs_cnt;
    for (int i = 0; i < 3; i++) push(32'h200 + 32'(i), 1'b0, 64'h5);
    cyc();
    chk("t4_send", {127'd0, m_axis_tvalid}, 128'd1);
    enable = 1'b0;
    cyc(8);
    chk("t4_pops", 128'(pops), 128'(n_pops0 + 1));
    chk("t4_hs", 128'(hs_cnt), 128'(n_hs0 + 1));
    chk("t4_busy", {127'd0, busy}, 128'd0);
    chk("t4_event", {96'd0, event_count}, 128'd12);

    // 5: clear_stats coincident with a handshake
    enable = 1'b1;
    cyc();
    chk("t5_send", {127'd0, m_axis_tvalid}, 128'd1);
    clear_stats = 1'b1;
    cyc();
    clear_stats = 1'b0;
    chk("t5_evt_clr", {96'd0, event_count}, 128'd0);
    chk("t5_stall_clr", {96'd0, stall_count}, 128'd0);
    chk("t5_seq_a", {112'd0, hs_data[hs_cnt - 1][127:112]}, 128'd12);
    cyc(6);
    chk("t5_event", {96'd0, event_count}, 128'd1);
    chk("t5_seq_b", {112'd0, hs_data[hs_cnt - 1][127:112]}, 128'd13);
    chk("t5_drop", {96'd0, drop_count}, 128'd0);

    // Asynchronous reset in the middle of a record
    m_axis_tready = 1'b0;
    push(32'h300, 1'b1, 64'h7);
    cyc();
    chk("rst_mid_pre", {127'd0, m_axis_tvalid}, 128'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_mid_tvalid", {127'd0, m_axis_tvalid}, 128'd0);
    chk("rst_mid_tdata", m_axis_tdata, 128'd0);
    chk("rst_mid_event", {96'd0, event_count}, 128'd0);
    cyc();
    resetn = 1'b1;
    cyc();

`ifdef CMAC_BP_DROP_EN
    // 6: permanent stall -> drop after DROP_TO cycles, then the next entry is popped
    n_pops0 = pops;
    push(32'h400, 1'b0, 64'h8);
    push(32'h401, 1'b0, 64'h9);
    cyc();
    chk("t6_send", {127'd0, m_axis_tvalid}, 128'd1);
    cyc(DROP_TO - 1);
    chk("t6_still", {127'd0, m_axis_tvalid}, 128'd1);
    cyc();
    chk("t6_dropped", {127'd0, m_axis_tvalid}, 128'd0);
    chk("t6_drop_cnt", {96'd0, drop_count}, 128'd1);
    chk("t6_event", {96'd0, event_count}, 128'd0);
    chk("t6_stall", {96'd0, stall_count}, 128'(DROP_TO));
    cyc();
    chk("t6_next", {127'd0, m_axis_tvalid}, 128'd1);
    chk("t6_pops", 128'(pops), 128'(n_pops0 + 2));
    chk("t6_seq", {112'd0, m_axis_tdata[127:112]}, 128'd0);
    m_axis_tready = 1'b1;
    cyc(4);
`endif

    chk("end_viol", 128'(viol), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
